// File: rtl/ucsbece154a_controller.sv
// Multicycle MIPS control unit: Moore main FSM plus combinational ALU decoder.
// Outputs decode from the state register only (BRANCH pcwrite also uses zero_i); never stalls.
module ucsbece154a_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    output logic       pcwrite_o,
    output logic       memwrite_o,
    output logic       irwrite_o,
    output logic       regwrite_o,
    output logic       iord_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic       memtoreg_o,
    output logic       regdst_o,
    output logic [1:0] pcsrc_o,
    output logic [2:0] alucontrol_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       pcwrite_c, memwrite_c, irwrite_c, regwrite_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Unknown opcodes fall back to FETCH, skipping the instruction.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op_i == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (op_i == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        iord_o     = 1'b0;
        alusrca_o  = 1'b0;
        alusrcb_o  = 2'b00;
        memtoreg_o = 1'b0;
        regdst_o   = 1'b0;
        pcsrc_o    = 2'b00;
        aluop      = 2'b00;
        case (state_q)
            S_FETCH: begin
                irwrite_c = 1'b1;
                pcwrite_c = 1'b1;
                alusrcb_o = 2'b01;
            end
            S_DECODE: begin
                alusrcb_o = 2'b11;
            end
            S_MEMADR, S_ADDIEXEC: begin
                alusrca_o = 1'b1;
                alusrcb_o = 2'b10;
            end
            S_MEMREAD: begin
                iord_o = 1'b1;
            end
            S_MEMWB: begin
                memtoreg_o = 1'b1;
                regwrite_c = 1'b1;
            end
            S_MEMWRITE: begin
                iord_o     = 1'b1;
                memwrite_c = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_o = 1'b1;
                aluop     = 2'b10;
            end
            S_ALUWB: begin
                regdst_o   = 1'b1;
                regwrite_c = 1'b1;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
            end
            S_BRANCH: begin
                alusrca_o = 1'b1;
                aluop     = 2'b01;
                pcsrc_o   = 2'b01;
                pcwrite_c = zero_i;
            end
            S_JUMP: begin
                pcsrc_o   = 2'b10;
                pcwrite_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alucontrol_o = 3'b010;
        case (aluop)
            2'b01: alucontrol_o = 3'b110;
            2'b10: begin
                case (funct_i)
                    FN_ADD:  alucontrol_o = 3'b010;
                    FN_SUB:  alucontrol_o = 3'b110;
                    FN_AND:  alucontrol_o = 3'b000;
                    FN_OR:   alucontrol_o = 3'b001;
                    FN_SLT:  alucontrol_o = 3'b111;
                    default: alucontrol_o = 3'b010;
                endcase
            end
            default: alucontrol_o = 3'b010;
        endcase
    end

    // The state is already FETCH during reset; only the write enables need masking.
    assign pcwrite_o  = reset_n & pcwrite_c;
    assign memwrite_o = reset_n & memwrite_c;
    assign irwrite_o  = reset_n & irwrite_c;
    assign regwrite_o = reset_n & regwrite_c;
    assign state_o    = state_q;

endmodule
